player_input: RTL and testbench
===============================

PLAYER_INPUT -- requirements
Module: player_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the number of consecutive stable cycles required before a press or release is accepted; it SHALL be at least 2.
REQ-002 The block SHALL have port ph1, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port keyValid, input, 1 bit: raw key-down level from the keypad encoder, asynchronous to ph1.
REQ-005 The block SHALL have port keyCode, input, 4 bits: raw cell code, asynchronous, meaningful while keyValid is high.
REQ-006 The block SHALL have port gBoard, input, 18 bits: board state, where cell n (1..9) occupies gBoard[2n-1:2n-2] and 2'b00 means empty.
REQ-007 The block SHALL have port gameIsDone, input, 1 bit: the game is over, so moves are ignored.
REQ-008 The block SHALL have port playerWrite, output, 1 bit: a single-cycle accepted-move strobe to the game controller.
REQ-009 The block SHALL have port playerInput, output, 4 bits: the accepted cell address (1..9).
REQ-010 The block SHALL have port invalidMove, output, 1 bit: a single-cycle strobe marking a rejected press.

Function
REQ-011 keyValid and keyCode SHALL each pass through a two-flop synchronizer; all further logic SHALL use only the synchronized values (keyValid_s, keyCode_s).
REQ-012 The FSM SHALL use exactly these states: IDLE, DEBOUNCE, VALIDATE, WAIT_RELEASE.
REQ-013 In IDLE, keyValid_s=1 SHALL cause entry to DEBOUNCE with the counter at 1 and keyCode_s latched as candidate code.
REQ-014 In DEBOUNCE, if keyValid_s=0 or keyCode_s differs from the candidate, the FSM SHALL return to IDLE and the counter SHALL clear.
REQ-015 In DEBOUNCE, when the counter reaches DEBOUNCE_CYCLES with the input still stable, the FSM SHALL enter VALIDATE; otherwise the counter SHALL increment.
REQ-016 VALIDATE SHALL last exactly one cycle, after which the FSM SHALL go to WAIT_RELEASE unconditionally.
REQ-017 In VALIDATE with gameIsDone=1, the block SHALL assert neither playerWrite nor invalidMove.
REQ-018 In VALIDATE with gameIsDone=0, a candidate in 1..9 whose gBoard cell equals 2'b00 SHALL be accepted: playerWrite high for exactly the next cycle, and playerInput loaded with the candidate in the same edge.
REQ-019 In VALIDATE with gameIsDone=0, a candidate of 0, a candidate of 10..15, or an occupied cell SHALL cause invalidMove high for exactly the next cycle, with playerInput unchanged.
REQ-020 playerInput SHALL hold its value until the next accepted move.
REQ-021 playerWrite and invalidMove SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-022 In WAIT_RELEASE, the counter SHALL count consecutive cycles with keyValid_s=0; any keyValid_s=1 SHALL clear it; reaching DEBOUNCE_CYCLES SHALL return the FSM to IDLE, so a held key produces exactly one strobe.
REQ-023 Latency: with keyValid and keyCode stable from rising edge k, playerWrite (or invalidMove) SHALL be high in the cycle between edges k+D+3 and k+D+4, where D=DEBOUNCE_CYCLES.
REQ-024 gBoard and gameIsDone SHALL be sampled only in VALIDATE; changes in other states SHALL have no effect.
REQ-025 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap.

Reset
REQ-026 While reset=0, asynchronously: FSM=IDLE, counter=0, candidate=0, synchronizer flops=0, playerWrite=0, playerInput=4'b0000, invalidMove=0.
REQ-027 Reset deasserted mid-press SHALL restart from IDLE; the interrupted press SHALL produce no strobe.

Verification
REQ-028 Scenario (D=4): keyCode=5 and keyValid=1 from edge 10, board empty -> playerWrite=1 only between edges 17 and 18, playerInput=5, invalidMove=0 throughout.
REQ-029 Scenario: keyValid held high for 100 cycles with code 3 -> exactly one playerWrite; release for 4+ cycles, then press again -> a second playerWrite.
REQ-030 Scenario: keyValid bounces 1,0,1 at 1-cycle spacing, then stays stable -> no strobe until a full D stable cycles after the last bounce.
REQ-031 Scenario: gBoard[9:8]=2'b11 with keyCode=5 -> invalidMove pulse, playerWrite=0, playerInput retains its prior value; keyCode=0 or 12 -> invalidMove pulse.
REQ-032 Scenario: gameIsDone=1 with a valid empty cell pressed -> no playerWrite and no invalidMove.
REQ-033 Scenario: reset=0 asserted during DEBOUNCE, deasserted while the key is still held -> all outputs 0, then a fresh accept occurs D+3 edges after the first post-reset edge.

Source files
------------

// File: rtl/player_input.sv
// Player keypad front end: synchronizes the raw key, debounces press and release,
// then checks the debounced cell code against the board and issues a one-cycle
// accept or reject strobe to the game controller.
module player_input #(
    // Must be at least 2.
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        keyValid,
    input  logic [3:0]  keyCode,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    output logic        playerWrite,
    output logic [3:0]  playerInput,
    output logic        invalidMove
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        VALIDATE,
        WAIT_RELEASE
    } state_t;

    logic          keyValid_m, keyValid_s;
    logic [3:0]    keyCode_m, keyCode_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          pw_d, inv_d;
    logic [3:0]    pin_d;

    logic          cand_ok;
    logic          cell_empty;

    // Two-flop synchronizers for the asynchronous keypad inputs.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            keyValid_m <= 1'b0;
            keyValid_s <= 1'b0;
            keyCode_m  <= 4'b0000;
            keyCode_s  <= 4'b0000;
        end else begin
            keyValid_m <= keyValid;
            keyValid_s <= keyValid_m;
            keyCode_m  <= keyCode;
            keyCode_s  <= keyCode_m;
        end
    end

    // Look up the candidate's board cell; codes outside 1..9 are never legal.
    always_comb begin
        cand_ok    = 1'b0;
        cell_empty = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (cand_q == 4'(n)) begin
                cand_ok    = 1'b1;
                cell_empty = (gBoard[2*n-2 +: 2] == 2'b00);
            end
        end
    end

    // FSM, counter, candidate and registered output strobes.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'b0000;
            playerWrite <= 1'b0;
            invalidMove <= 1'b0;
            playerInput <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            playerWrite <= pw_d;
            invalidMove <= inv_d;
            playerInput <= pin_d;
        end
    end

    // Next-state logic: debounce press, judge once, then debounce release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        pw_d    = 1'b0;
        inv_d   = 1'b0;
        pin_d   = playerInput;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (keyValid_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CW'(1);
                    cand_d  = keyCode_s;
                end
            end
            DEBOUNCE: begin
                if (!keyValid_s || (keyCode_s != cand_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = VALIDATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            VALIDATE: begin
                // Board and game-over flag only matter in this one cycle.
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
                if (!gameIsDone) begin
                    if (cand_ok && cell_empty) begin
                        pw_d  = 1'b1;
                        pin_d = cand_q;
                    end else begin
                        inv_d = 1'b1;
                    end
                end
            end
            WAIT_RELEASE: begin
                // Any bounce back to pressed restarts the release count.
                if (keyValid_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: table of single presses plus hand-written sequences
// for held keys, bounce, late board changes and reset mid-press. Expected strobes
// (cycle, kind, cell) are queued when a press is driven and matched when seen.
module tb_player_input;

    localparam int unsigned D = 4;

    logic        ph1;
    logic        reset;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic        invalidMove;

    player_input #(.DEBOUNCE_CYCLES(D)) dut (
        .ph1         (ph1),
        .reset       (reset),
        .keyValid    (keyValid),
        .keyCode     (keyCode),
        .gBoard      (gBoard),
        .gameIsDone  (gameIsDone),
        .playerWrite (playerWrite),
        .playerInput (playerInput),
        .invalidMove (invalidMove)
    );

    typedef struct {
        int         cyc;
        logic       pw;
        logic       inv;
        logic [3:0] pin;
    } exp_t;

    typedef struct {
        logic [3:0]  code;
        logic [17:0] board;
        logic        done;
        logic        exp_pw;
        logic        exp_inv;
        logic [3:0]  exp_pin;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    always @(posedge ph1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ph1);
    endtask

    // Strobe at the negedge after edge c+D+4 when the press is driven after edge c.
    task automatic expect_strobe(input logic pw, input logic inv, input logic [3:0] pin);
        exp_t e;
        e.cyc = cyc + int'(D) + 4;
        e.pw  = pw;
        e.inv = inv;
        e.pin = pin;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] code, input logic [17:0] board, input logic done,
                         input logic e_pw, input logic e_inv, input logic [3:0] e_pin,
                         input int hold);
        keyCode    = code;
        gBoard     = board;
        gameIsDone = done;
        keyValid   = 1'b1;
        if (e_pw || e_inv) expect_strobe(e_pw, e_inv, e_pin);
        wait_cycles(hold);
        keyValid = 1'b0;
        wait_cycles(int'(D) + 10);
        chk("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    // Match every strobe the DUT produces against the queued expectations.
    always @(negedge ph1) begin
        exp_t e;
        if (playerWrite || invalidMove) begin
            chk("strobes_exclusive", {31'b0, playerWrite & invalidMove}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'b0, playerWrite, invalidMove}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                chk("strobe_outputs", {26'b0, playerWrite, invalidMove, playerInput},
                    {26'b0, e.pw, e.inv, e.pin});
            end
        end
    end

    initial begin
        //          code   board      done pw    inv   pin
        vecs[0]  = '{4'd5,  18'h00000, 1'b0, 1'b1, 1'b0, 4'd5};
        vecs[1]  = '{4'd2,  18'h00000, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[2]  = '{4'd5,  18'h00300, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[3]  = '{4'd0,  18'h00000, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[4]  = '{4'd12, 18'h00000, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[5]  = '{4'd9,  18'h10000, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[6]  = '{4'd9,  18'h00000, 1'b0, 1'b1, 1'b0, 4'd9};
        vecs[7]  = '{4'd1,  18'h0000C, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[8]  = '{4'd1,  18'h00002, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[9]  = '{4'd7,  18'h00000, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{4'd10, 18'h00000, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[11] = '{4'd15, 18'h00000, 1'b1, 1'b0, 1'b0, 4'd1};

        reset      = 1'b0;
        keyValid   = 1'b0;
        keyCode    = 4'd0;
        gBoard     = 18'h0;
        gameIsDone = 1'b0;
        wait_cycles(3);
        chk("reset_playerWrite", {31'b0, playerWrite}, 32'd0);
        chk("reset_invalidMove", {31'b0, invalidMove}, 32'd0);
        chk("reset_playerInput", {28'b0, playerInput}, 32'd0);
        reset = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 12; i++) begin
            press(vecs[i].code, vecs[i].board, vecs[i].done,
                  vecs[i].exp_pw, vecs[i].exp_inv, vecs[i].exp_pin, int'(D) + 10);
        end

        // Board freed during debounce: only the value seen in VALIDATE counts.
        keyCode    = 4'd4;
        gBoard     = 18'h000C0;
        gameIsDone = 1'b0;
        keyValid   = 1'b1;
        expect_strobe(1'b1, 1'b0, 4'd4);
        wait_cycles(3);
        gBoard = 18'h0;
        wait_cycles(int'(D) + 7);
        keyValid = 1'b0;
        wait_cycles(int'(D) + 10);
        chk("late_board_drained", 32'(sb.size()), 32'd0);

        // Long hold gives one strobe; a fresh press after release gives another.
        press(4'd3, 18'h0, 1'b0, 1'b1, 1'b0, 4'd3, 100);
        press(4'd3, 18'h0, 1'b0, 1'b1, 1'b0, 4'd3, int'(D) + 10);

        // Bounce 1,0,1: the debounce window restarts at the last rising edge.
        keyCode  = 4'd6;
        keyValid = 1'b1;
        wait_cycles(1);
        keyValid = 1'b0;
        wait_cycles(1);
        keyValid = 1'b1;
        expect_strobe(1'b1, 1'b0, 4'd6);
        wait_cycles(int'(D) + 10);
        keyValid = 1'b0;
        wait_cycles(int'(D) + 10);
        chk("bounce_drained", 32'(sb.size()), 32'd0);

        // Reset mid-debounce while the key stays held.
        keyCode  = 4'd8;
        keyValid = 1'b1;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(1);
        chk("midreset_playerWrite", {31'b0, playerWrite}, 32'd0);
        chk("midreset_invalidMove", {31'b0, invalidMove}, 32'd0);
        chk("midreset_playerInput", {28'b0, playerInput}, 32'd0);
        wait_cycles(1);
        reset = 1'b1;
        expect_strobe(1'b1, 1'b0, 4'd8);
        wait_cycles(int'(D) + 10);
        keyValid = 1'b0;
        wait_cycles(int'(D) + 10);
        chk("midreset_drained", 32'(sb.size()), 32'd0);
        chk("final_playerInput", {28'b0, playerInput}, 32'd8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
